// File: rtl/dma_rq_read_logic.sv
// dma_rq_read_logic: turns a host-to-card read descriptor into a stream of
// single-beat PCIe Memory Read request descriptors on the 256-bit RQ
// AXI-Stream. It owns the tag window and tracks outstanding tags until the
// completion receiver frees them. No request crosses a 4 KB boundary, and no
// request is larger than 2**C_LOG2_MAX_READ_REQUEST bytes.
// Optional feature: define DMA_RQ_TAG_TIMEOUT_EN to add a per-tag timeout
// that force-frees a stuck tag and flags it in ERROR_TAGS.
module dma_rq_read_logic #(
    parameter int C_BUS_DATA_WIDTH        = 256,
    parameter int C_BUS_KEEP_WIDTH        = C_BUS_DATA_WIDTH / 32,
    parameter int C_WINDOW_SIZE           = 16,
    parameter int C_LOG2_MAX_READ_REQUEST = 9,
    parameter int C_TIMEOUT_CYCLES        = 65535
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          DESC_VALID,
    output logic                          DESC_READY,
    input  logic [63:0]                   DESC_ADDR,
    input  logic [31:0]                   DESC_BYTES,
    output logic [C_BUS_DATA_WIDTH-1:0]   M_AXIS_RQ_TDATA,
    output logic [59:0]                   M_AXIS_RQ_TUSER,
    output logic                          M_AXIS_RQ_TLAST,
    output logic [C_BUS_KEEP_WIDTH-1:0]   M_AXIS_RQ_TKEEP,
    output logic                          M_AXIS_RQ_TVALID,
    input  logic                          M_AXIS_RQ_TREADY,
    input  logic [63:0]                   CURRENT_WINDOW_SIZE,
    output logic [C_WINDOW_SIZE-1:0]      BUSY_TAGS,
    output logic [C_WINDOW_SIZE*11-1:0]   SIZE_TAGS,
    input  logic [C_WINDOW_SIZE-1:0]      COMPLETED_TAGS,
    output logic [63:0]                   WORD_COUNT,
    output logic                          DONE,
    output logic [C_WINDOW_SIZE-1:0]      ERROR_TAGS
);

    localparam int          TAG_W  = (C_WINDOW_SIZE > 1) ? $clog2(C_WINDOW_SIZE) : 1;
    localparam int          CNT_W  = $clog2(C_WINDOW_SIZE + 1);
    localparam logic [12:0] MAX_RQ = 13'(1 << C_LOG2_MAX_READ_REQUEST);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_TAG   = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]                         state_q, state_d;
    logic [63:0]                        addr_q, addr_d;
    logic [31:0]                        rem_q, rem_d;
    logic [12:0]                        chunk_q, chunk_d;
    logic [10:0]                        dw_q, dw_d;
    logic [TAG_W-1:0]                   tag_q, tag_d;
    logic [63:0]                        word_q, word_d;
    logic [C_WINDOW_SIZE-1:0]           busy_q, busy_d;
    logic [C_WINDOW_SIZE-1:0][10:0]     size_q, size_d;

    logic [12:0]      boundary;
    logic [12:0]      chunk_calc;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] limit;
    logic             free_found;
    logic [TAG_W-1:0] free_tag;
    logic             issue;

`ifdef DMA_RQ_TAG_TIMEOUT_EN
    logic [C_WINDOW_SIZE-1:0]       err_q, err_d;
    logic [C_WINDOW_SIZE-1:0][15:0] tmo_q, tmo_d;
`endif

    assign issue = (state_q == S_SEND) && M_AXIS_RQ_TREADY;

    // Chunk size: limited by remaining bytes, max read request and the 4 KB page end.
    always_comb begin
        boundary   = 13'h1000 - {1'b0, addr_q[11:0]};
        chunk_calc = (rem_q < 32'(MAX_RQ)) ? rem_q[12:0] : MAX_RQ;
        if (boundary < chunk_calc) chunk_calc = boundary;
    end

    // Outstanding-tag count, effective window limit and lowest free tag.
    always_comb begin
        busy_cnt   = '0;
        free_found = 1'b0;
        free_tag   = '0;
        for (int i = 0; i < C_WINDOW_SIZE; i++) begin
            busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_tag   = TAG_W'(i);
            end
        end
        limit = (CURRENT_WINDOW_SIZE == 64'd0 || CURRENT_WINDOW_SIZE > 64'(C_WINDOW_SIZE))
              ? CNT_W'(C_WINDOW_SIZE) : CURRENT_WINDOW_SIZE[CNT_W-1:0];
    end

    // Request FSM next state plus tag bookkeeping.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        chunk_d = chunk_q;
        dw_d    = dw_q;
        tag_d   = tag_q;
        word_d  = word_q;
        busy_d  = busy_q & ~COMPLETED_TAGS;
        size_d  = size_q;
`ifdef DMA_RQ_TAG_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (DESC_VALID) begin
                    addr_d  = DESC_ADDR;
                    rem_d   = DESC_BYTES;
                    word_d  = '0;
`ifdef DMA_RQ_TAG_TIMEOUT_EN
                    err_d   = '0;
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                chunk_d = chunk_calc;
                dw_d    = chunk_calc[12:2];
                state_d = S_TAG;
            end
            S_TAG: begin
                if (free_found && busy_cnt < limit) begin
                    tag_d   = free_tag;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (issue) begin
                    busy_d[tag_q] = 1'b1;
                    size_d[tag_q] = dw_q;
                    addr_d        = addr_q + 64'(chunk_q);
                    rem_d         = rem_q - 32'(chunk_q);
                    word_d        = word_q + 64'(dw_q);
                    state_d       = (rem_q == 32'(chunk_q)) ? S_DRAIN : S_CALC;
                end
            end
            S_DRAIN: begin
                if (busy_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef DMA_RQ_TAG_TIMEOUT_EN
        for (int j = 0; j < C_WINDOW_SIZE; j++) begin
            if (busy_q[j] && tmo_q[j] == 16'(C_TIMEOUT_CYCLES)) begin
                busy_d[j] = 1'b0;
                err_d[j]  = 1'b1;
            end
        end
`endif
    end

`ifdef DMA_RQ_TAG_TIMEOUT_EN
    // Per-tag age counters: cleared on issue, counting while the tag is busy.
    always_comb begin
        for (int j = 0; j < C_WINDOW_SIZE; j++) begin
            tmo_d[j] = busy_q[j] ? tmo_q[j] + 16'd1 : tmo_q[j];
            if (issue && tag_q == TAG_W'(j)) tmo_d[j] = '0;
        end
    end

    // Timeout state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= '0;
            tmo_q <= '0;
        end else begin
            err_q <= err_d;
            tmo_q <= tmo_d;
        end
    end

    assign ERROR_TAGS = err_q;
`else
    assign ERROR_TAGS = '0;
`endif

    // FSM and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            dw_q    <= '0;
            tag_q   <= '0;
            word_q  <= '0;
            busy_q  <= '0;
            // NOTE: the per-tag size table is reset because the completion side reads it.
            size_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            chunk_q <= chunk_d;
            dw_q    <= dw_d;
            tag_q   <= tag_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            size_q  <= size_d;
        end
    end

    // Request descriptor beat, driven only while a TLP is being offered.
    always_comb begin
        M_AXIS_RQ_TDATA = '0;
        M_AXIS_RQ_TUSER = '0;
        M_AXIS_RQ_TKEEP = '0;
        M_AXIS_RQ_TLAST = 1'b0;
        if (state_q == S_SEND) begin
            M_AXIS_RQ_TDATA[63:2]   = addr_q[63:2];
            M_AXIS_RQ_TDATA[74:64]  = dw_q;
            M_AXIS_RQ_TDATA[103:96] = 8'(tag_q);
            M_AXIS_RQ_TUSER[3:0]    = 4'hF;
            M_AXIS_RQ_TUSER[7:4]    = (dw_q > 11'd1) ? 4'hF : 4'h0;
            M_AXIS_RQ_TKEEP         = C_BUS_KEEP_WIDTH'(8'h0F);
            M_AXIS_RQ_TLAST         = 1'b1;
        end
    end

    assign M_AXIS_RQ_TVALID = (state_q == S_SEND);
    assign DESC_READY       = (state_q == S_IDLE);
    assign DONE             = (state_q == S_DRAIN) && (busy_q == '0);
    assign BUSY_TAGS        = busy_q;
    assign SIZE_TAGS        = size_q;
    assign WORD_COUNT       = word_q;

endmodule

// File: tb/tb_dma_rq_read_logic.sv
// Directed bench for dma_rq_read_logic: splitting, 4 KB boundary, window
// stall and tag reuse, single-dword byte enables, back-pressure hold, async
// reset mid-send, and (with DMA_RQ_TAG_TIMEOUT_EN) the tag timeout.
module tb_dma_rq_read_logic;

    localparam int W = 16;

    logic              CLK;
    logic              RST_N;
    logic              DESC_VALID;
    logic              DESC_READY;
    logic [63:0]       DESC_ADDR;
    logic [31:0]       DESC_BYTES;
    logic [255:0]      M_AXIS_RQ_TDATA;
    logic [59:0]       M_AXIS_RQ_TUSER;
    logic              M_AXIS_RQ_TLAST;
    logic [7:0]        M_AXIS_RQ_TKEEP;
    logic              M_AXIS_RQ_TVALID;
    logic              M_AXIS_RQ_TREADY;
    logic [63:0]       CURRENT_WINDOW_SIZE;
    logic [W-1:0]      BUSY_TAGS;
    logic [W*11-1:0]   SIZE_TAGS;
    logic [W-1:0]      COMPLETED_TAGS;
    logic [63:0]       WORD_COUNT;
    logic              DONE;
    logic [W-1:0]      ERROR_TAGS;

    dma_rq_read_logic #(
        .C_BUS_DATA_WIDTH        (256),
        .C_WINDOW_SIZE           (W),
        .C_LOG2_MAX_READ_REQUEST (9),
        .C_TIMEOUT_CYCLES        (100)
    ) dut (
        .CLK                 (CLK),
        .RST_N               (RST_N),
        .DESC_VALID          (DESC_VALID),
        .DESC_READY          (DESC_READY),
        .DESC_ADDR           (DESC_ADDR),
        .DESC_BYTES          (DESC_BYTES),
        .M_AXIS_RQ_TDATA     (M_AXIS_RQ_TDATA),
        .M_AXIS_RQ_TUSER     (M_AXIS_RQ_TUSER),
        .M_AXIS_RQ_TLAST     (M_AXIS_RQ_TLAST),
        .M_AXIS_RQ_TKEEP     (M_AXIS_RQ_TKEEP),
        .M_AXIS_RQ_TVALID    (M_AXIS_RQ_TVALID),
        .M_AXIS_RQ_TREADY    (M_AXIS_RQ_TREADY),
        .CURRENT_WINDOW_SIZE (CURRENT_WINDOW_SIZE),
        .BUSY_TAGS           (BUSY_TAGS),
        .SIZE_TAGS           (SIZE_TAGS),
        .COMPLETED_TAGS      (COMPLETED_TAGS),
        .WORD_COUNT          (WORD_COUNT),
        .DONE                (DONE),
        .ERROR_TAGS          (ERROR_TAGS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected request descriptor for a given address, dword count and tag.
    function automatic logic [255:0] exp_desc(input logic [63:0] a, input logic [10:0] dw,
                                              input logic [7:0] t);
        logic [255:0] d;
        d          = '0;
        d[63:0]    = a;
        d[74:64]   = dw;
        d[103:96]  = t;
        return d;
    endfunction

    // Accepted TLPs, captured on the falling edge before the handshake edge.
    logic [255:0] tlp_q[$];
    logic [59:0]  user_q[$];
    always @(negedge CLK) begin
        if (RST_N && M_AXIS_RQ_TVALID && M_AXIS_RQ_TREADY) begin
            tlp_q.push_back(M_AXIS_RQ_TDATA);
            user_q.push_back(M_AXIS_RQ_TUSER);
        end
    end

    task automatic send_desc(input logic [63:0] a, input logic [31:0] b);
        int k = 0;
        @(negedge CLK);
        while (!DESC_READY && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check("desc_ready_wait", DESC_READY, 1'b1);
        DESC_VALID = 1'b1;
        DESC_ADDR  = a;
        DESC_BYTES = b;
        @(negedge CLK);
        DESC_VALID = 1'b0;
    endtask

    task automatic wait_tlps(input int n, input string tag);
        int k = 0;
        while (tlp_q.size() < n && k < 500) begin
            @(negedge CLK);
            k++;
        end
        check(tag, (tlp_q.size() >= n), 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!M_AXIS_RQ_TVALID && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check(tag, M_AXIS_RQ_TVALID, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!DONE && k < 500) begin
            @(negedge CLK);
            k++;
        end
        check(tag, DONE, 1'b1);
    endtask

    task automatic complete(input logic [W-1:0] mask);
        @(negedge CLK);
        COMPLETED_TAGS = mask;
        @(negedge CLK);
        COMPLETED_TAGS = '0;
    endtask

    initial begin
        RST_N               = 1'b0;
        DESC_VALID          = 1'b0;
        DESC_ADDR           = '0;
        DESC_BYTES          = '0;
        M_AXIS_RQ_TREADY    = 1'b1;
        CURRENT_WINDOW_SIZE = 64'd16;
        COMPLETED_TAGS      = '0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_ready", DESC_READY, 1'b1);
        check("rst_tvalid", M_AXIS_RQ_TVALID, 1'b0);
        check("rst_busy", BUSY_TAGS, '0);
        check("rst_size", SIZE_TAGS, '0);
        check("rst_wc", WORD_COUNT, '0);
        check("rst_done", DONE, 1'b0);
        check("rst_err", ERROR_TAGS, '0);
        RST_N = 1'b1;

        // Test 1: 2048 B at 0x1000 -> four 512 B requests, tags 0..3
        tlp_q.delete();
        user_q.delete();
        send_desc(64'h1000, 32'd2048);
        wait_tlps(4, "t1_count");
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_tlp%0d", i), tlp_q[i], exp_desc(64'h1000 + 64'(i * 512), 11'd128, 8'(i)));
            check($sformatf("t1_user%0d", i), user_q[i], 60'hFF);
        end
        check("t1_busy", BUSY_TAGS, 16'h000F);
        check("t1_size3", SIZE_TAGS[3*11 +: 11], 11'd128);
        complete(16'h000F);
        wait_done("t1_done");
        check("t1_ready_at_done", DESC_READY, 1'b0);
        check("t1_wc", WORD_COUNT, 64'd512);
        @(negedge CLK);
        check("t1_done_pulse", DONE, 1'b0);
        check("t1_ready_after", DESC_READY, 1'b1);

        // Test 2: 512 B at 0x0F80 -> split at the 4 KB boundary
        CURRENT_WINDOW_SIZE = 64'd100;
        tlp_q.delete();
        user_q.delete();
        send_desc(64'h0F80, 32'd512);
        wait_tlps(2, "t2_count");
        check("t2_tlp0", tlp_q[0], exp_desc(64'h0F80, 11'd32, 8'd0));
        check("t2_tlp1", tlp_q[1], exp_desc(64'h1000, 11'd96, 8'd1));
        check("t2_user1", user_q[1], 60'hFF);
        complete(16'h0003);
        wait_done("t2_done");
        check("t2_wc", WORD_COUNT, 64'd128);

        // Test 3: window of 2 stalls, freed tag 0 reissued two cycles after its pulse
        CURRENT_WINDOW_SIZE = 64'd2;
        tlp_q.delete();
        user_q.delete();
        send_desc(64'h2000, 32'd4096);
        wait_tlps(2, "t3_count");
        repeat (20) @(negedge CLK);
        check("t3_stall_count", tlp_q.size(), 2);
        check("t3_stall_busy", BUSY_TAGS, 16'h0003);
        check("t3_tlp0", tlp_q[0], exp_desc(64'h2000, 11'd128, 8'd0));
        check("t3_tlp1", tlp_q[1], exp_desc(64'h2200, 11'd128, 8'd1));
        @(negedge CLK);
        COMPLETED_TAGS = 16'h0001;
        @(negedge CLK);
        COMPLETED_TAGS = '0;
        check("t3_gap_valid", M_AXIS_RQ_TVALID, 1'b0);
        @(negedge CLK);
        check("t3_reuse_valid", M_AXIS_RQ_TVALID, 1'b1);
        check("t3_reuse_tlp", M_AXIS_RQ_TDATA, exp_desc(64'h2400, 11'd128, 8'd0));
        @(negedge CLK);
        M_AXIS_RQ_TREADY = 1'b0;
        repeat (4) @(negedge CLK);
        complete(16'h0002);
        wait_valid("t3_tlp3_valid");
        check("t3_tlp3", M_AXIS_RQ_TDATA, exp_desc(64'h2600, 11'd128, 8'd1));
        check("t3_wc", WORD_COUNT, 64'd384);

        // Test 5: asynchronous reset while a TLP is being offered
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("t5_tvalid", M_AXIS_RQ_TVALID, 1'b0);
        check("t5_busy", BUSY_TAGS, '0);
        check("t5_ready", DESC_READY, 1'b1);
        check("t5_wc", WORD_COUNT, '0);
        check("t5_size", SIZE_TAGS, '0);
        @(negedge CLK);
        RST_N               = 1'b1;
        CURRENT_WINDOW_SIZE = 64'd0;

        // Test 4: single dword, back-pressure holds the beat stable
        tlp_q.delete();
        user_q.delete();
        send_desc(64'h3000, 32'd4);
        wait_valid("t4_valid");
        check("t4_tlp", M_AXIS_RQ_TDATA, exp_desc(64'h3000, 11'd1, 8'd0));
        check("t4_user", M_AXIS_RQ_TUSER, 60'h0F);
        check("t4_keep", M_AXIS_RQ_TKEEP, 8'h0F);
        check("t4_last", M_AXIS_RQ_TLAST, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check($sformatf("t4_hold_valid%0d", i), M_AXIS_RQ_TVALID, 1'b1);
            check($sformatf("t4_hold_data%0d", i), M_AXIS_RQ_TDATA, exp_desc(64'h3000, 11'd1, 8'd0));
        end
        M_AXIS_RQ_TREADY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("t4_after_valid", M_AXIS_RQ_TVALID, 1'b0);
        check("t4_busy", BUSY_TAGS, 16'h0001);
        check("t4_size0", SIZE_TAGS[10:0], 11'd1);
        complete(16'h0001);
        wait_done("t4_done");
        check("t4_wc", WORD_COUNT, 64'd1);

`ifdef DMA_RQ_TAG_TIMEOUT_EN
        // Test 6: tag 0 never completes, the timeout frees it and flags it
        begin
            int c;
            c = 0;
            tlp_q.delete();
            user_q.delete();
            send_desc(64'h4000, 32'd4);
            wait_tlps(1, "t6_count");
            while (!DONE && c < 300) begin
                @(negedge CLK);
                c++;
            end
            check("t6_done", DONE, 1'b1);
            check("t6_delay", (c >= 95 && c <= 110), 1'b1);
            check("t6_err", ERROR_TAGS, 16'h0001);
            check("t6_busy", BUSY_TAGS, '0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_rq_read_logic.md
Name: dma_rq_read_logic

Overview:
DMA requester-request transmitter. It converts a host-to-card read descriptor into a sequence of PCIe Memory Read request TLPs on the 256-bit requester-request AXI-Stream (UltraScale RQ descriptor format, no straddle). It owns the tag window. It drives BUSY_TAGS and SIZE_TAGS into the requester-completion receiver and frees tags on its COMPLETED_TAGS pulses.

Parameters:
C_BUS_DATA_WIDTH, 256, RQ stream data width (only 256 supported)
C_BUS_KEEP_WIDTH, C_BUS_DATA_WIDTH/32, tkeep width
C_WINDOW_SIZE, 16, number of tags / max outstanding requests (<=256)
C_LOG2_MAX_READ_REQUEST, 9, max read request in bytes = 2**value (7..12)
C_TIMEOUT_CYCLES, 65535, tag timeout (optional feature only)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
DESC_VALID  in  1  descriptor valid
DESC_READY  out  1  descriptor accepted when VALID&READY
DESC_ADDR  in  64  host byte address, bits[1:0] must be 0
DESC_BYTES  in  32  transfer length in bytes, multiple of 4, nonzero
M_AXIS_RQ_TDATA  out  C_BUS_DATA_WIDTH  request descriptor
M_AXIS_RQ_TUSER  out  60  first_be[3:0], last_be[7:4], rest 0
M_AXIS_RQ_TLAST  out  1  always 1 when valid (single beat)
M_AXIS_RQ_TKEEP  out  C_BUS_KEEP_WIDTH  8'h0F
M_AXIS_RQ_TVALID  out  1  TLP valid
M_AXIS_RQ_TREADY  in  1  core ready
CURRENT_WINDOW_SIZE  in  64  runtime outstanding limit, 0 = C_WINDOW_SIZE
BUSY_TAGS  out  C_WINDOW_SIZE  tag outstanding
SIZE_TAGS  out  C_WINDOW_SIZE*11  per-tag requested dword count
COMPLETED_TAGS  in  C_WINDOW_SIZE  one-cycle tag-done pulses
WORD_COUNT  out  64  dwords issued in current transfer
DONE  out  1  one-cycle pulse: transfer issued and all tags freed
ERROR_TAGS  out  C_WINDOW_SIZE  sticky timed-out tags (0 without feature)

Behaviour:
- Reset: all outputs 0 except DESC_READY=1; FSM in IDLE; SIZE_TAGS 0.
- FSM IDLE: DESC_READY=1; on VALID&READY latch addr and bytes, clear WORD_COUNT, go CALC.
- CALC (1 cycle): chunk = min(remaining, 2**C_LOG2_MAX_READ_REQUEST, 4096-addr[11:0]). Request never crosses a 4 KB boundary. dwcount = chunk>>2 (11 bits, 1..1024). Go TAG.
- TAG: limit = CURRENT_WINDOW_SIZE==0 or >C_WINDOW_SIZE ? C_WINDOW_SIZE : CURRENT_WINDOW_SIZE. Wait while popcount(BUSY_TAGS)>=limit or no free tag. Otherwise select the lowest-index free tag and go SEND.
- SEND: TVALID=1, held stable until TREADY.
  - Descriptor layout: TDATA[63:2]=addr[63:2]; [1:0]=0; [74:64]=dwcount; [78:75]=4'b0000 (MRd); [103:96]=tag; all other bits 0.
  - first_be=4'hF; last_be=4'hF if dwcount>1, else 4'h0.
  - On handshake: set BUSY_TAGS[tag], SIZE_TAGS[tag]=dwcount; addr+=chunk, remaining-=chunk, WORD_COUNT+=dwcount.
  - Next state: CALC if remaining!=0, else DRAIN.
- DRAIN: wait for BUSY_TAGS==0, then DONE=1 for 1 cycle and go IDLE. DESC_READY=1 again in the cycle after DONE.
- Tag release: a COMPLETED_TAGS[j] pulse clears BUSY_TAGS[j] next cycle; SIZE_TAGS[j] is retained. A freed tag is selectable from the cycle after the clear.
- COMPLETED_TAGS on a non-busy tag is ignored.
- Simultaneous issue and completion on different tags both take effect the same cycle.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous); any TLP in flight is abandoned.
- Widths: remaining is 32-bit; addr arithmetic is 64-bit with wrap ignored.

Optional Feature:
DMA_RQ_TAG_TIMEOUT_EN
- Defined:
  - Per-tag counter (16 bits) clears on issue and increments while busy.
  - On reaching C_TIMEOUT_CYCLES, BUSY_TAGS[j] clears and ERROR_TAGS[j] sets (sticky until the next DESC accept).
  - DRAIN completes normally.
- Undefined:
  - No counters; ERROR_TAGS tied 0.
  - DRAIN waits indefinitely.

Test Plan:
1. DESC_ADDR=0x1000, BYTES=2048, window 16, TREADY=1 -> 4 TLPs, dwcount=128 each, tags 0..3, addrs 0x1000/0x1200/0x1400/0x1600. Complete all tags -> DONE pulse, WORD_COUNT=512.
2. ADDR=0x0F80, BYTES=512 -> two TLPs: 128 B (dwcount 32) at 0x0F80, then 384 B (dwcount 96) at 0x1000.
3. CURRENT_WINDOW_SIZE=2, BYTES=4096, no completions -> exactly 2 TLPs then stall. Pulse COMPLETED_TAGS[0] -> next TLP reuses tag 0 two cycles later.
4. BYTES=4 -> dwcount=1, first_be=F, last_be=0. TREADY low for 5 cycles -> TVALID and TDATA held stable.
5. Assert RST_N low during SEND -> TVALID=0, BUSY_TAGS=0, DESC_READY=1 immediately.
6. With DMA_RQ_TAG_TIMEOUT_EN, C_TIMEOUT_CYCLES=100, never complete tag 0 -> after 100 cycles ERROR_TAGS[0]=1, BUSY_TAGS[0]=0, DONE pulses.
